gbus_burst_writer: RTL
======================

// Module: gbus_burst_writer
// PURPOSE
//  Global-bus write initiator: the transmit end of the in_gbus write port that each core decodes.
//  Takes one burst command (head bias, core index, start CMEM address, word count) and a valid/ready word stream.
//  Emits one gbus write per accepted word, at consecutive CMEM addresses.
//  Sits in the head/top-level controller and fills core CMEMs with weights and activations.
// PARAMETERS
//  GBUS_DATA_WIDTH      32  width of each gbus write word
//  BUS_CMEM_ADDR_WIDTH  13  CMEM word-address field, addr[12:0]
//  BUS_CORE_ADDR_WIDTH   4  core-index field, addr[16:13]
//  HEAD_SRAM_BIAS_WIDTH  2  head/SRAM bias field, addr[18:17]
//  LEN_WIDTH            14  burst length counter width; maximum length is 8192 words
// PORTS
//  clk            in   1   clock; all logic on posedge
//  rstn           in   1   asynchronous active-low reset
//  cmd_vld        in   1   burst command valid
//  cmd_rdy        out  1   command accepted when cmd_vld & cmd_rdy
//  cmd_head       in   2   head/SRAM bias field (0 = CMEM)
//  cmd_core       in   4   target core index
//  cmd_addr       in   13  first CMEM word address
//  cmd_len        in   14  number of words in the burst, 0..8192
//  wr_data        in   32  payload word
//  wr_data_vld    in   1   payload valid
//  wr_data_rdy    out  1   payload word consumed when wr_data_vld & wr_data_rdy
//  gbus_addr      out  19  {head, core, cmem_addr}
//  gbus_wen       out  1   single-cycle write strobe
//  gbus_wdata     out  32  write data
//  busy           out  1   high while a burst is in progress (states RUN and DONE)
//  done           out  1   one-cycle pulse when a burst completes
//  wrap_err       out  1   sticky flag: CMEM address wrapped during the current burst
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_rdy = 1. FSM is in IDLE; counters and registers are 0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: cmd_rdy = 1.
//    - On cmd accept, latch head, core, addr and len.
//    - Clear wrap_err.
//    - If cmd_len == 0, go to DONE; otherwise go to RUN.
//   RUN: cmd_rdy = 0, wr_data_rdy = 1.
//    - Each accepted word drives one gbus write on the next cycle, then increments the address and decrements the remaining count.
//    - When the last word is accepted, go to DONE. wr_data_rdy drops in the cycle after the last accept.
//   DONE: done = 1 for exactly one cycle, then go to IDLE. cmd_rdy returns high the cycle after DONE.
//  Latency: word accepted at cycle N produces gbus_wen = 1 at N+1.
//   - gbus_addr, gbus_wdata and gbus_wen are all registered.
//   - gbus_wen = 0 in every cycle that has no accepted word in the previous cycle.
//   - gbus_addr and gbus_wdata hold their last values while gbus_wen = 0.
//  Gaps: wr_data_vld may drop at any time in RUN. The address and count advance only on accepted words.
//   Back-to-back accepts give one write per cycle.
//  Address: cmem address is a 13-bit counter, so 8191 + 1 wraps to 0.
//   On a wrap that occurs while words remain, set wrap_err. It holds until the next command is accepted.
//  Write ordering: the final gbus write (N+1) lands in the same cycle as the done pulse.
//  Commands are ignored, not queued, while busy (cmd_rdy = 0).
//  No gbus backpressure: the gbus always accepts a write.
//  Reset asserted mid-burst: immediate return to IDLE. Any pending write is dropped; no done pulse is produced.
// TESTING
//  T1 cmd head=0 core=3 addr=0x010 len=4, data A0..A3 back-to-back
//     -> 4 writes at gbus_addr 0x06010..0x06013 on consecutive cycles; done on the cycle of the 4th write.
//  T2 same burst with wr_data_vld toggling 1,0,0,1,1,0,1
//     -> 4 writes, each one cycle after its accept; addresses contiguous; no write in gap cycles.
//  T3 cmd addr=0x1FFE len=4
//     -> writes at CMEM 0x1FFE, 0x1FFF, 0x0000, 0x0001; wrap_err = 1 after the third write; cleared by the next cmd.
//  T4 cmd len=0
//     -> no gbus_wen; done pulses 1 cycle after the accept cycle; cmd_rdy high again the following cycle.
//  T5 second cmd_vld held during a len=8 burst
//     -> cmd_rdy = 0 until after done; second cmd accepted in IDLE and its burst runs correctly.
//  T6 rstn low after 3 of 8 words
//     -> outputs at reset values, no done pulse; a new len=2 burst then completes normally.

Source files
------------

// File: rtl/gbus_burst_writer_if.sv
// Burst-writer bus bundle: command, payload stream and gbus write port.
// master = controller/gbus side, slave = the writer itself.
interface gbus_burst_writer_if #(
  parameter int GBUS_DATA_WIDTH      = 32,
  parameter int BUS_CMEM_ADDR_WIDTH  = 13,
  parameter int BUS_CORE_ADDR_WIDTH  = 4,
  parameter int HEAD_SRAM_BIAS_WIDTH = 2,
  parameter int LEN_WIDTH            = 14
);
  localparam int GA_W = HEAD_SRAM_BIAS_WIDTH
                      + BUS_CORE_ADDR_WIDTH
                      + BUS_CMEM_ADDR_WIDTH;

  logic                            cmd_vld;
  logic                            cmd_rdy;
  logic [HEAD_SRAM_BIAS_WIDTH-1:0] cmd_head;
  logic [BUS_CORE_ADDR_WIDTH-1:0]  cmd_core;
  logic [BUS_CMEM_ADDR_WIDTH-1:0]  cmd_addr;
  logic [LEN_WIDTH-1:0]            cmd_len;
  logic [GBUS_DATA_WIDTH-1:0]      wr_data;
  logic                            wr_data_vld;
  logic                            wr_data_rdy;
  logic [GA_W-1:0]                 gbus_addr;
  logic                            gbus_wen;
  logic [GBUS_DATA_WIDTH-1:0]      gbus_wdata;

  modport master (
    output cmd_vld, cmd_head, cmd_core,
    output cmd_addr, cmd_len,
    output wr_data, wr_data_vld,
    input  cmd_rdy, wr_data_rdy,
    input  gbus_addr, gbus_wen, gbus_wdata
  );

  modport slave (
    input  cmd_vld, cmd_head, cmd_core,
    input  cmd_addr, cmd_len,
    input  wr_data, wr_data_vld,
    output cmd_rdy, wr_data_rdy,
    output gbus_addr, gbus_wen, gbus_wdata
  );
endinterface

// File: rtl/gbus_burst_writer.sv
// Global-bus burst write initiator: turns one burst command plus a
// valid/ready word stream into consecutive-address gbus writes.
module gbus_burst_writer #(
  parameter int GBUS_DATA_WIDTH      = 32,
  parameter int BUS_CMEM_ADDR_WIDTH  = 13,
  parameter int BUS_CORE_ADDR_WIDTH  = 4,
  parameter int HEAD_SRAM_BIAS_WIDTH = 2,
  parameter int LEN_WIDTH            = 14
) (
  input  logic               clk,
  input  logic               rstn,
  gbus_burst_writer_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               wrap_err
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [HEAD_SRAM_BIAS_WIDTH-1:0] head_q;
  logic [BUS_CORE_ADDR_WIDTH-1:0]  core_q;
  logic [BUS_CMEM_ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]            rem_q;

  logic cmd_fire;
  logic wr_fire;
  logic last_word;

  assign cmd_fire  = bus.cmd_vld & bus.cmd_rdy;
  assign wr_fire   = bus.wr_data_vld & bus.wr_data_rdy;
  assign last_word = (rem_q == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      head_q         <= '0;
      core_q         <= '0;
      addr_q         <= '0;
      rem_q          <= '0;
      bus.cmd_rdy    <= 1'b1;
      bus.wr_data_rdy <= 1'b0;
      bus.gbus_addr  <= '0;
      bus.gbus_wen   <= 1'b0;
      bus.gbus_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wrap_err       <= 1'b0;
    end else begin
      bus.gbus_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            head_q      <= bus.cmd_head;
            core_q      <= bus.cmd_core;
            addr_q      <= bus.cmd_addr;
            rem_q       <= bus.cmd_len;
            wrap_err    <= 1'b0;
            busy        <= 1'b1;
            bus.cmd_rdy <= 1'b0;
            if (bus.cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state           <= RUN;
              bus.wr_data_rdy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_fire) begin
            bus.gbus_wen   <= 1'b1;
            bus.gbus_addr  <= {head_q, core_q, addr_q};
            bus.gbus_wdata <= bus.wr_data;
            addr_q <= addr_q + BUS_CMEM_ADDR_WIDTH'(1);
            rem_q  <= rem_q - LEN_WIDTH'(1);
            // counter rolls past the top of CMEM with words still to go
            if ((&addr_q) && !last_word)
              wrap_err <= 1'b1;
            if (last_word) begin
              state           <= DONE;
              bus.wr_data_rdy <= 1'b0;
              done            <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          bus.cmd_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
